// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and helpers for the sync_fifo write arbiter
package sync_fifo_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, FLUSH = 2'd2} arb_state_t;

   localparam int MAX_REQ = 16;

   function automatic int arb_id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Returns {found, index}; scan starts just after last and wraps modulo n.
   function automatic logic [4:0] rr_pick_fn(input logic [MAX_REQ-1:0] valid, input logic [3:0] last, input int n);
      logic       found;
      logic [3:0] idx;
      int         j;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         j = (int'(last) + k) % n;
         if (k <= n && !found && valid[j]) begin
            found = 1'b1;
            idx   = 4'(j);
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder
module rr_pick
   import sync_fifo_pkg::*;
#(
   parameter int N = 4,
   parameter int W = arb_id_w(N)
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] last,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [4:0] r;

   assign r     = rr_pick_fn(MAX_REQ'(valid), 4'(last), N);
   assign found = r[4];
   assign idx   = W'(r[3:0]);

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// sync_fifo_wr_arbiter: burst-locked round-robin arbiter in front of a sync_fifo write port
module sync_fifo_wr_arbiter
   import sync_fifo_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          flush,
   input  logic                          fifo_full,
   input  logic                          fifo_afull,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic                          fifo_wr_en,
   output logic                          fifo_sclr,
   output logic [arb_id_w(NUM_REQ)-1:0]  grant_id,
   output logic                          busy
);

   localparam int IW = arb_id_w(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_t    state, state_nx;
   logic [IW-1:0] rr_last, rr_last_nx, grant_nx, pick_idx;
   logic [BW-1:0] beat_cnt, beat_nx;
   logic          pick_found, sclr_q, rdy, xfer, last_beat;

   rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
      .valid (req_valid),
      .last  (rr_last),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign busy         = state == GRANT;
   assign rdy          = busy & ~fifo_full & ~flush;
   assign req_ready    = rdy ? NUM_REQ'(1) << grant_id : '0;
   assign xfer         = rdy & req_valid[grant_id];
   assign fifo_wr_en   = xfer;
   assign fifo_data_in = busy ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign fifo_sclr    = sclr_q;
   assign last_beat    = beat_cnt == BW'(MAX_BURST - 1);

   always_comb begin
      state_nx   = state;
      grant_nx   = grant_id;
      rr_last_nx = rr_last;
      beat_nx    = beat_cnt;
      if (state == IDLE) begin
         if (flush) state_nx = FLUSH;
         else if (pick_found && !fifo_afull) begin
            state_nx = GRANT;
            grant_nx = pick_idx;
            beat_nx  = '0;
         end
      end else if (state == GRANT) begin
         // A dropped valid ends the burst even while ready is held high.
         if (flush) state_nx = FLUSH;
         else if (!req_valid[grant_id] || (xfer && last_beat)) begin
            state_nx   = IDLE;
            rr_last_nx = grant_id;
         end
         if (xfer) beat_nx = beat_cnt + BW'(1);
      end else begin
         state_nx = flush ? FLUSH : IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_last  <= IW'(NUM_REQ - 1);
         beat_cnt <= '0;
         sclr_q   <= 1'b0;
      end else begin
         state    <= state_nx;
         grant_id <= grant_nx;
         rr_last  <= rr_last_nx;
         beat_cnt <= beat_nx;
         sclr_q   <= state_nx == FLUSH;
      end
   end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// tb_sync_fifo_wr_arbiter: randomized scenario bench with a behavioural arbiter model
module tb_sync_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int MB = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            flush = 1'b0, fifo_full = 1'b0, fifo_afull = 1'b0;
   logic [DW-1:0]   fifo_data_in;
   logic            fifo_wr_en, fifo_sclr, busy;
   logic [1:0]      grant_id;

   sync_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .flush        (flush),
      .fifo_full    (fifo_full),
      .fifo_afull   (fifo_afull),
      .fifo_data_in (fifo_data_in),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_sclr    (fifo_sclr),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0, cyc = 0;

   // producer streams: each beat carries {requester, sequence number}
   int           rem[N];
   int           seq[N];
   logic [N-1:0] en = '0;
   logic [N-1:0] hs = '0;

   // behavioural arbiter: 0 idle, 1 owning the port, 2 clearing the fifo
   int m_st, m_own, m_last, m_cnt;

   function automatic int first_valid(input int last);
      for (int k = 1; k <= N; k++)
         if (req_valid[(last + k) % N]) return (last + k) % N;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st <= 0; m_own <= 0; m_last <= N - 1; m_cnt <= 0;
      end else if (m_st == 0) begin
         if (flush) m_st <= 2;
         else if (req_valid != 0 && !fifo_afull) begin
            m_st <= 1; m_cnt <= 0; m_own <= first_valid(m_last);
         end
      end else if (m_st == 1) begin
         if (flush) m_st <= 2;
         else if (!req_valid[m_own]) begin
            m_st <= 0; m_last <= m_own;
         end else if (!fifo_full) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == MB) begin
               m_st <= 0; m_last <= m_own;
            end
         end
      end else begin
         m_st <= flush ? 2 : 0;
      end
   end

   logic [N-1:0]  e_ready;
   logic [DW-1:0] e_data;
   logic [40:0]   obs_v, exp_v;

   always_comb begin
      e_ready = '0;
      if (m_st == 1 && !fifo_full && !flush) e_ready[m_own] = 1'b1;
      e_data = (m_st == 1) ? {8'(m_own), 24'(seq[m_own])} : '0;
   end

   assign obs_v = {busy, req_ready, fifo_wr_en, fifo_sclr, grant_id, fifo_data_in};
   assign exp_v = {m_st == 1, e_ready, |(e_ready & req_valid), m_st == 2, 2'(m_own), e_data};

   function automatic int rem_total();
      int s = 0;
      for (int i = 0; i < N; i++) s += rem[i];
      return s;
   endfunction

   task automatic tick(input logic full, input logic afull, input logic fl);
      @(negedge clk);
      for (int i = 0; i < N; i++) if (hs[i]) begin rem[i]--; seq[i]++; end
      fifo_full  = full;
      fifo_afull = afull;
      flush      = fl;
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = en[i] && rem[i] > 0;
         req_data[i*DW +: DW]  = {8'(i), 24'(seq[i])};
      end
      #1;
      hs = e_ready & req_valid;
      cyc++;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      hs = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // burst trace of the DUT as seen on its outputs
   int b_id[$], b_len[$], gaps[$];
   int idle_wr, trace_bad;
   bit timed_out;

   task automatic run_bursts(input int budget);
      int beats = 0, gap = 0, n = 0;
      logic wb;
      bit done = 0;
      b_id.delete(); b_len.delete(); gaps.delete();
      idle_wr = 0; trace_bad = 0;
      wb = busy;
      while (n < budget && !done) begin
         tick(1'b0, 1'b0, 1'b0);
         n++;
         if (obs_v !== exp_v) begin
            trace_bad++;
            if (trace_bad < 5) $display("note: cyc=%0d dut=%h model=%h", cyc, obs_v, exp_v);
         end
         if (busy) begin
            if (!wb) begin b_id.push_back(int'(grant_id)); gaps.push_back(gap); gap = 0; beats = 0; end
            if (fifo_wr_en) beats++;
         end else begin
            if (wb) b_len.push_back(beats);
            gap++;
            if (fifo_wr_en) idle_wr++;
         end
         wb = busy;
         if (!busy && rem_total() == 0) done = 1;
      end
      timed_out = !done;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
      checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", fifo_wr_en); end
      checks++; if (fifo_sclr !== 1'b0) begin failures++; $display("FAIL reset_sclr got=%b exp=0", fifo_sclr); end
      checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
      checks++; if (fifo_data_in !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", fifo_data_in); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_priority_burst();
      int exp_id[4]  = '{0, 2, 0, 2};
      int exp_len[4] = '{16, 16, 4, 4};
      en = 4'b0101; rem[0] = 20; rem[2] = 20;
      run_bursts(200);
      checks++; if (timed_out) begin failures++; $display("FAIL prio_timeout got=timeout exp=drained"); end
      checks++; if (trace_bad != 0) begin failures++; $display("FAIL prio_trace got=%0d diffs exp=0", trace_bad); end
      checks++; if (b_id.size() != 4 || b_len.size() != 4) begin
         failures++; $display("FAIL prio_count got=%0d/%0d exp=4/4", b_id.size(), b_len.size()); end
      for (int k = 0; k < 4; k++) begin
         int gi, gl, gg;
         gi = k < b_id.size() ? b_id[k] : -1;
         gl = k < b_len.size() ? b_len[k] : -1;
         gg = k < gaps.size() ? gaps[k] : -1;
         checks++;
         if (gi != exp_id[k] || gl != exp_len[k] || gg != 1) begin
            failures++;
            $display("FAIL prio_burst%0d got id=%0d len=%0d gap=%0d exp id=%0d len=%0d gap=1", k, gi, gl, gg, exp_id[k], exp_len[k]);
         end
      end
      checks++; if (idle_wr != 0) begin failures++; $display("FAIL prio_idle_wr got=%0d exp=0", idle_wr); end
   endtask

   task automatic test_round_robin();
      int exp_id[5] = '{0, 1, 2, 3, 0};
      reset_dut();
      en = 4'b1111; rem[0] = 32; rem[1] = 16; rem[2] = 16; rem[3] = 16;
      run_bursts(200);
      checks++; if (timed_out || trace_bad != 0) begin
         failures++; $display("FAIL rr_trace got timeout=%0d diffs=%0d exp=0/0", timed_out, trace_bad); end
      checks++; if (b_id.size() != 5) begin failures++; $display("FAIL rr_count got=%0d exp=5", b_id.size()); end
      for (int k = 0; k < 5; k++) begin
         int gi, gl;
         gi = k < b_id.size() ? b_id[k] : -1;
         gl = k < b_len.size() ? b_len[k] : -1;
         checks++;
         if (gi != exp_id[k] || gl != MB) begin
            failures++; $display("FAIL rr_grant%0d got id=%0d len=%0d exp id=%0d len=%0d", k, gi, gl, exp_id[k], MB);
         end
      end
   endtask

   task automatic test_full_stall();
      int w = 0, n = 0;
      en = 4'b0010; rem[1] = 20;
      while (w < 5 && n < 40) begin
         tick(1'b0, 1'b0, 1'b0); n++;
         checks++; if (obs_v !== exp_v) begin failures++; $display("FAIL stall_pre got=%h exp=%h", obs_v, exp_v); end
         if (fifo_wr_en) w++;
      end
      checks++; if (w != 5) begin failures++; $display("FAIL stall_reach got=%0d beats exp=5", w); end
      for (int k = 0; k < 5; k++) begin
         tick(1'b1, 1'b0, 1'b0);
         checks++;
         if (req_ready !== '0 || fifo_wr_en !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd1) begin
            failures++;
            $display("FAIL stall_hold%0d got ready=%b wr=%b busy=%b gid=%0d exp ready=0 wr=0 busy=1 gid=1", k, req_ready, fifo_wr_en, busy, grant_id);
         end
      end
      run_bursts(80);
      checks++; if (timed_out || trace_bad != 0) begin
         failures++; $display("FAIL stall_trace got timeout=%0d diffs=%0d exp=0/0", timed_out, trace_bad); end
      checks++;
      if (b_len.size() != 2 || b_len[0] != 11 || b_len[1] != 4) begin
         failures++; $display("FAIL stall_total got first=%0d bursts=%0d exp first=11 bursts=2", b_len.size() > 0 ? b_len[0] : -1, b_len.size());
      end
   endtask

   task automatic test_afull();
      int w;
      en = 4'b1000; rem[3] = 3;
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 1'b1, 1'b0);
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL afull_block%0d got busy=%b exp=0", k, busy); end
      end
      tick(1'b0, 1'b0, 1'b0);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL afull_arb got busy=%b exp=0", busy); end
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd3) begin
         failures++; $display("FAIL afull_grant got busy=%b gid=%0d exp busy=1 gid=3", busy, grant_id);
      end
      w = fifo_wr_en ? 1 : 0;
      run_bursts(30);
      checks++;
      if (timed_out || trace_bad != 0 || b_len.size() < 1 || w + b_len[0] != 3) begin
         failures++; $display("FAIL afull_burst got timeout=%0d diffs=%0d beats=%0d exp 0/0/3", timed_out, trace_bad, b_len.size() > 0 ? w + b_len[0] : -1);
      end
   endtask

   task automatic test_flush();
      int w = 0, n = 0;
      en = 4'b0001; rem[0] = 2;
      run_bursts(30);
      checks++; if (b_id.size() != 1 || b_id[0] != 0) begin
         failures++; $display("FAIL flush_setup got bursts=%0d exp one to req0", b_id.size()); end
      en = 4'b0010; rem[1] = 10;
      while (w < 5 && n < 40) begin
         tick(1'b0, 1'b0, 1'b0); n++;
         if (fifo_wr_en) w++;
      end
      checks++; if (w != 5) begin failures++; $display("FAIL flush_reach got=%0d beats exp=5", w); end
      tick(1'b0, 1'b0, 1'b1);
      checks++;
      if (busy !== 1'b1 || req_ready !== '0 || fifo_wr_en !== 1'b0) begin
         failures++; $display("FAIL flush_req got busy=%b ready=%b wr=%b exp 1/0/0", busy, req_ready, fifo_wr_en);
      end
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (fifo_sclr !== 1'b1 || fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL flush_sclr got sclr=%b wr=%b busy=%b exp 1/0/0", fifo_sclr, fifo_wr_en, busy);
      end
      en = 4'b0110; rem[2] = 3;
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (fifo_sclr !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL flush_end got sclr=%b busy=%b exp 0/0", fifo_sclr, busy);
      end
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd1) begin
         failures++; $display("FAIL flush_next got busy=%b gid=%0d exp busy=1 gid=1", busy, grant_id);
      end
      run_bursts(80);
      checks++; if (timed_out || trace_bad != 0) begin
         failures++; $display("FAIL flush_trace got timeout=%0d diffs=%0d exp=0/0", timed_out, trace_bad); end
   endtask

   task automatic test_async_reset();
      int w = 0, n = 0;
      en = 4'b0011; rem[0] = 10; rem[1] = 10;
      while (w < 3 && n < 40) begin
         tick(1'b0, 1'b0, 1'b0); n++;
         if (fifo_wr_en) w++;
      end
      checks++; if (w != 3 || busy !== 1'b1) begin failures++; $display("FAIL areset_reach got beats=%0d busy=%b exp 3/1", w, busy); end
      #2;
      rst_n = 1'b0;
      hs = '0;
      #1;
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL areset_ready got=%b exp=0", req_ready); end
      checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL areset_wr got=%b exp=0", fifo_wr_en); end
      checks++; if (fifo_sclr !== 1'b0) begin failures++; $display("FAIL areset_sclr got=%b exp=0", fifo_sclr); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd0) begin
         failures++; $display("FAIL areset_first got busy=%b gid=%0d exp busy=1 gid=0", busy, grant_id);
      end
      run_bursts(100);
      checks++; if (timed_out || trace_bad != 0) begin
         failures++; $display("FAIL areset_trace got timeout=%0d diffs=%0d exp=0/0", timed_out, trace_bad); end
   endtask

   task automatic test_random();
      logic full, afull, fl;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++)
            if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = $urandom_range(1, 20);
         if ($urandom_range(0, 15) == 0) en = N'($urandom);
         full  = $urandom_range(0, 3) == 0;
         afull = $urandom_range(0, 4) == 0;
         fl    = $urandom_range(0, 29) == 0;
         tick(full, afull, fl);
         checks++;
         if (obs_v !== exp_v) begin
            failures++; $display("FAIL rand cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
      test_reset();
      test_priority_burst();
      test_round_robin();
      test_full_stall();
      test_afull();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
